// File: rtl/soc_design_pio_pkg.sv
// -----------------------------------------------------------------------------
// soc_design_pio_pkg
// Shared definitions for the extended parallel I/O peripheral:
//   - register word addresses (pio_addr_e)
//   - EDGE_TYPE encodings (EDGE_RISE / EDGE_FALL / EDGE_ANY)
//   - decoded bus request record (pio_req_t)
//   - per-bit edge detector helper (edge_event)
// -----------------------------------------------------------------------------
package soc_design_pio_pkg;

  // Register word addresses; 6 and 7 are reserved and fall to the defaults.
  typedef enum logic [2:0] {
    ADDR_DATA_OUT = 3'd0,
    ADDR_DATA_IN  = 3'd1,
    ADDR_IRQ_MASK = 3'd2,
    ADDR_EDGE_CAP = 3'd3,
    ADDR_OUTSET   = 3'd4,
    ADDR_OUTCLEAR = 3'd5
  } pio_addr_e;

  // Edge selection for the input capture logic.
  localparam int EDGE_RISE = 32'sd0;
  localparam int EDGE_FALL = 32'sd1;
  localparam int EDGE_ANY  = 32'sd2;

  // One bus cycle after strobe qualification.
  typedef struct packed {
    logic        wr;
    logic        rd;
    pio_addr_e   addr;
    logic [31:0] wdata;
  } pio_req_t;

  // Edge event for one bit given the synchronised value and its history.
  // Unknown encodings fall back to rising-edge behaviour.
  function automatic logic edge_event(input logic s, input logic d, input int edge_type);
    logic ev;
    case (edge_type)
      EDGE_RISE: ev = s & ~d;
      EDGE_FALL: ev = ~s & d;
      EDGE_ANY:  ev = s ^ d;
      default:   ev = s & ~d;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/soc_design_pio_ext_if.sv
// -----------------------------------------------------------------------------
// soc_design_pio_ext_if
// Avalon-MM slave bus bundle for the PIO peripheral.
//   address[2:0]    register word address
//   chipselect      slave select
//   read            read strobe (qualified by chipselect)
//   write_n         active-low write strobe (qualified by chipselect)
//   writedata[31:0] write data
//   readdata[31:0]  read data, one cycle after the read strobe
// master modport: interconnect side; slave modport: peripheral side.
// -----------------------------------------------------------------------------
interface soc_design_pio_ext_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_design_pio_sync.sv
// -----------------------------------------------------------------------------
// soc_design_pio_sync
// Input conditioning for the PIO: SYNC_STAGES-deep synchroniser, one history
// flop, and per-bit edge events. Events are held off for SYNC_STAGES+1 cycles
// after reset so inputs already high at reset release are not captured.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_async[DW-1:0]     asynchronous external inputs
//   o_sync[DW-1:0]      synchronised inputs
//   o_event[DW-1:0]     per-bit edge event (one cycle per detected edge)
// -----------------------------------------------------------------------------
module soc_design_pio_sync
  import soc_design_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_async,
  output logic [DATA_WIDTH-1:0] o_sync,
  output logic [DATA_WIDTH-1:0] o_event
);

  // Counter wide enough to hold SYNC_STAGES+1.
  localparam int                SUPP_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [SUPP_W-1:0] SUPP_INIT = SUPP_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
  logic [DATA_WIDTH-1:0]                  r_sync_d;
  logic [SUPP_W-1:0]                      r_supp_cnt;
  logic [DATA_WIDTH-1:0]                  w_sync;
  logic [DATA_WIDTH-1:0]                  w_event;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser chain, history flop and post-reset suppression countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= '0;
      r_sync_d   <= '0;
      r_supp_cnt <= SUPP_INIT;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_sync_d <= w_sync;
      if (r_supp_cnt != '0) begin
        r_supp_cnt <= r_supp_cnt - SUPP_W'(1);
      end else begin
        r_supp_cnt <= r_supp_cnt;
      end
    end
  end

  // Per-bit edge detection, gated off while the suppression count runs.
  always_comb begin
    w_event = '0;
    if (r_supp_cnt == '0) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        w_event[i] = edge_event(w_sync[i], r_sync_d[i], EDGE_TYPE);
      end
    end else begin
      w_event = '0;
    end
  end

  assign o_sync  = w_sync;
  assign o_event = w_event;

endmodule

// File: rtl/soc_design_pio_ext.sv
// -----------------------------------------------------------------------------
// soc_design_pio_ext
// Avalon-MM parallel I/O peripheral: DATA_WIDTH output register with atomic
// set/clear, synchronised input with per-bit edge capture, maskable level irq.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   bus (slave)     Avalon-MM register access, read latency 1, no wait states
//   in_port         asynchronous external inputs
//   out_port        output register contents
//   irq             level interrupt, |(EDGE_CAP & IRQ_MASK), registered
// -----------------------------------------------------------------------------
module soc_design_pio_ext
  import soc_design_pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int          EDGE_TYPE   = EDGE_RISE,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  soc_design_pio_ext_if.slave   bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  pio_req_t              w_req;
  logic [DATA_WIDTH-1:0] w_wd;
  logic                  w_unused_wdata;
  logic [DATA_WIDTH-1:0] w_sync;
  logic [DATA_WIDTH-1:0] w_event;

  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] r_irq_mask;
  logic [DATA_WIDTH-1:0] r_edge_cap;
  logic [31:0]           r_readdata;
  logic                  r_irq;

  logic [DATA_WIDTH-1:0] w_data_out_nxt;
  logic [DATA_WIDTH-1:0] w_irq_mask_nxt;
  logic [DATA_WIDTH-1:0] w_w1c;
  logic [DATA_WIDTH-1:0] w_edge_cap_nxt;
  logic                  w_irq_nxt;
  logic [31:0]           w_rd_data;

  soc_design_pio_sync #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (in_port),
    .o_sync  (w_sync),
    .o_event (w_event)
  );

  // Qualify the strobes with chipselect and decode the address.
  always_comb begin
    w_req.wr    = bus.chipselect & ~bus.write_n;
    w_req.rd    = bus.chipselect & bus.read;
    w_req.addr  = pio_addr_e'(bus.address);
    w_req.wdata = bus.writedata;
  end

  // Write data above DATA_WIDTH is ignored by design.
  assign w_wd           = w_req.wdata[DATA_WIDTH-1:0];
  assign w_unused_wdata = ^w_req.wdata;

  // Register next-state: writes, set/clear, W1C and edge capture.
  always_comb begin
    w_data_out_nxt = r_data_out;
    w_irq_mask_nxt = r_irq_mask;
    w_w1c          = '0;
    if (w_req.wr) begin
      case (w_req.addr)
        ADDR_DATA_OUT: w_data_out_nxt = w_wd;
        ADDR_IRQ_MASK: w_irq_mask_nxt = w_wd;
        ADDR_EDGE_CAP: w_w1c          = w_wd;
        ADDR_OUTSET:   w_data_out_nxt = r_data_out | w_wd;
        ADDR_OUTCLEAR: w_data_out_nxt = r_data_out & ~w_wd;
        default:       w_w1c          = '0;
      endcase
    end else begin
      w_w1c = '0;
    end
    // A fresh event is OR-ed in after the clear, so a same-cycle set wins.
    w_edge_cap_nxt = (r_edge_cap & ~w_w1c) | w_event;
    // irq is registered from the next-state values so it tracks EDGE_CAP
    // in the same cycle while still coming straight out of a flop.
    w_irq_nxt      = |(w_edge_cap_nxt & w_irq_mask_nxt);
  end

  // Read mux; unused upper bits, reserved addresses and write-only
  // set/clear registers return zero.
  always_comb begin
    w_rd_data = 32'd0;
    if (w_req.rd) begin
      case (w_req.addr)
        ADDR_DATA_OUT: w_rd_data[DATA_WIDTH-1:0] = r_data_out;
        ADDR_DATA_IN:  w_rd_data[DATA_WIDTH-1:0] = w_sync;
        ADDR_IRQ_MASK: w_rd_data[DATA_WIDTH-1:0] = r_irq_mask;
        ADDR_EDGE_CAP: w_rd_data[DATA_WIDTH-1:0] = r_edge_cap;
        default:       w_rd_data                 = 32'd0;
      endcase
    end else begin
      w_rd_data = 32'd0;
    end
  end

  // Register file, read data and interrupt flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= RESET_VALUE[DATA_WIDTH-1:0];
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_readdata <= 32'd0;
      r_irq      <= 1'b0;
    end else begin
      r_data_out <= w_data_out_nxt;
      r_irq_mask <= w_irq_mask_nxt;
      r_edge_cap <= w_edge_cap_nxt;
      r_readdata <= w_rd_data;
      r_irq      <= w_irq_nxt;
    end
  end

  assign bus.readdata = r_readdata;
  assign out_port     = r_data_out;
  assign irq          = r_irq;

endmodule
